// File: rtl/mc_control.sv
// mc_control: multicycle processor control FSM with a saturating retired-instruction counter
module mc_control #(
  parameter int OPW       = 4,
  parameter int MCODEBITS = 9,
  parameter int ALUOPW    = 4,
  parameter int CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [MCODEBITS-1:0] Instr,
  input  logic                 MemReady,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 IRWrite,
  output logic                 Branch,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [ALUOPW-1:0]    ALUOp,
  output logic [1:0]           RegDst,
  output logic                 Halt,
  output logic                 Illegal,
  output logic [CNTW-1:0]      Retired
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;
  logic [2:0] state, next;
  logic [OPW-1:0] opcode;
  logic retire;
  logic is_load, is_store, is_bne, is_halt, is_ill, is_imm;
  logic [ALUOPW-1:0] alu_op;
  logic [1:0] wb_dst;
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[MCODEBITS-OPW-1:0];
  assign is_load  = opcode == OPW'(0);
  assign is_store = opcode == OPW'(1);
  assign is_bne   = opcode == OPW'(3);
  assign is_halt  = opcode == OPW'(10);
  assign is_ill   = opcode > OPW'(12);
  assign is_imm   = opcode inside {OPW'(6), OPW'(7), OPW'(8), OPW'(9)};
  assign alu_op = opcode == OPW'(2)  ? ALUOPW'(4'b0001) :
                  opcode == OPW'(3)  ? ALUOPW'(4'b0010) :
                  opcode == OPW'(4)  ? ALUOPW'(4'b0011) :
                  opcode == OPW'(6)  ? ALUOPW'(4'b0100) :
                  opcode == OPW'(7)  ? ALUOPW'(4'b0101) :
                  opcode == OPW'(9)  ? ALUOPW'(4'b1000) :
                  opcode == OPW'(11) ? ALUOPW'(4'b1010) :
                  opcode == OPW'(12) ? ALUOPW'(4'b1011) : ALUOPW'(4'b0111);
  assign wb_dst = opcode == OPW'(5) ? 2'd2 :
                  (is_load || opcode inside {OPW'(6), OPW'(7), OPW'(8)}) ? 2'd1 : 2'd0;
  // next-state and Moore/Mealy outputs from state, latched opcode, Zero and MemReady
  always_comb begin
    next     = state;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = ALUOPW'(4'b0111);
    RegDst   = 2'd0;
    Halt     = 1'b0;
    Illegal  = 1'b0;
    retire   = 1'b0;
    case (state)
      IDLE: next = Start ? FETCH : IDLE;
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        next    = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        Illegal = is_ill;
        PCWrite = is_ill;
        retire  = is_halt;
        next    = is_halt ? HALT : is_ill ? FETCH : EXEC;
      end
      EXEC: begin
        ALUOp   = alu_op;
        ALUSrc  = is_imm;
        Branch  = is_bne;
        PCWrite = is_bne;
        PCSrc   = is_bne & ~Zero;
        retire  = is_bne;
        next    = (is_load || is_store) ? MEM : is_bne ? FETCH : WB;
      end
      MEM: begin
        MemRead  = is_load;
        MemWrite = is_store;
        PCWrite  = is_store & MemReady;
        retire   = is_store & MemReady;
        next     = !MemReady ? MEM : is_load ? WB : FETCH;
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = is_load;
        RegDst   = wb_dst;
        retire   = 1'b1;
        next     = FETCH;
      end
      HALT: begin
        Halt = 1'b1;
        next = Start ? FETCH : HALT;
      end
      default: next = IDLE;
    endcase
  end
  // state, opcode latch and saturating retire counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      opcode  <= '0;
      Retired <= '0;
    end else begin
      state <= next;
      if (state == FETCH && MemReady) opcode <= Instr[MCODEBITS-1 -: OPW];
      if (retire && !(&Retired)) Retired <= Retired + CNTW'(1);
    end
  end
endmodule
